// File: rtl/response_handler_pkg.sv
// Protocol constants shared between the request decoder and the response path:
// response codes, frame length and the latched response frame layout.
package response_handler_pkg;

    localparam int BYTE_W    = 8;
    localparam int FRAME_LEN = 2;

    localparam logic [BYTE_W-1:0] BYTE_RESET = 8'h00;

    typedef enum logic [BYTE_W-1:0] {
        RESP_ACK    = 8'h06,
        RESP_STATUS = 8'h08,
        RESP_NAK    = 8'h15,
        RESP_ERROR  = 8'hEE
    } resp_code_e;

    typedef struct packed {
        logic [BYTE_W-1:0] code;
        logic [BYTE_W-1:0] data;
    } resp_frame_t;

    // Byte 0 of a frame is the code, byte 1 the payload.
    function automatic logic [BYTE_W-1:0] frame_byte(input resp_frame_t frame, input logic second);
        return second ? frame.data : frame.code;
    endfunction

endpackage

// File: rtl/response_handler_timer.sv
// Per-byte tx_done watchdog: cleared outside the wait states, counts while enabled,
// and flags expiry once the count reaches TIMEOUT_CYCLES-1.
module response_timer #(
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Saturates at LAST so the count can never wrap before the abort is taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/response_handler.sv
// Sends a two-byte response frame (code, then data) through a byte-wide UART
// transmitter handshake, with overrun reporting and a per-byte tx_done timeout.
module response_handler #(
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] response_code,
    input  logic [7:0] response_data,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       overrun,
    output logic       timeout
);

    import response_handler_pkg::*;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CODE,
        WAIT_CODE,
        SEND_DATA,
        WAIT_DATA
    } state_t;

    state_t      state, state_next;
    resp_frame_t frame_q, frame_next;
    logic        tx_start_next;
    logic [7:0]  tx_data_next;
    logic        busy_next;
    logic        overrun_next;
    logic        timeout_next;
    logic        timer_clear;
    logic        timer_enable;
    logic        timer_expired;

    response_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            frame_q  <= '0;
            tx_start <= 1'b0;
            tx_data  <= BYTE_RESET;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_next;
            frame_q  <= frame_next;
            tx_start <= tx_start_next;
            tx_data  <= tx_data_next;
            busy     <= busy_next;
            overrun  <= overrun_next;
            timeout  <= timeout_next;
        end
    end

    // A tx_done seen while tx_start is still high belongs to the previous byte, so
    // the wait states only honour it from the cycle after the launch onwards.
    always_comb begin
        state_next    = state;
        frame_next    = frame_q;
        tx_start_next = 1'b0;
        tx_data_next  = tx_data;
        busy_next     = busy;
        overrun_next  = send && busy;
        timeout_next  = 1'b0;
        timer_clear   = 1'b1;
        timer_enable  = 1'b0;

        case (state)
            IDLE: begin
                if (send) begin
                    frame_next.code = response_code;
                    frame_next.data = response_data;
                    state_next      = SEND_CODE;
                    busy_next       = 1'b1;
                end
            end
            SEND_CODE: begin
                if (!tx_busy) begin
                    tx_start_next = 1'b1;
                    tx_data_next  = frame_byte(frame_q, 1'b0);
                    state_next    = WAIT_CODE;
                end
            end
            WAIT_CODE: begin
                timer_clear  = 1'b0;
                timer_enable = 1'b1;
                if (tx_done && !tx_start) begin
                    state_next = SEND_DATA;
                end else if (timer_expired) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                    busy_next    = 1'b0;
                end
            end
            SEND_DATA: begin
                if (!tx_busy) begin
                    tx_start_next = 1'b1;
                    tx_data_next  = frame_byte(frame_q, 1'b1);
                    state_next    = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                timer_clear  = 1'b0;
                timer_enable = 1'b1;
                if (tx_done && !tx_start) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else if (timer_expired) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                    busy_next    = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_response_handler.sv
// Self-checking bench for response_handler: a UART stand-in answers each tx_start,
// and frame timing/bytes are predicted from the protocol rules by simple arithmetic.
module tb_response_handler;

    import response_handler_pkg::*;

    localparam int TMO    = 16;
    localparam int PERIOD = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       send = 1'b0;
    logic [7:0] response_code = 8'h00;
    logic [7:0] response_data = 8'h00;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       overrun;
    logic       timeout;

    logic busy_force = 1'b0;
    logic stray_done = 1'b0;
    logic uart_shift = 1'b0;
    logic uart_done  = 1'b0;
    int   done_delay = 10;
    bit   respond    = 1'b1;
    bit   prev_start = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int         start_cyc[$];
    logic [7:0] start_byte[$];
    int         ovr_cyc[$];
    int         tmo_cyc[$];
    logic [7:0] model_bytes[$];

    assign tx_busy = busy_force | uart_shift;
    assign tx_done = uart_done | stray_done;

    response_handler #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .send         (send),
        .response_code(response_code),
        .response_data(response_data),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .busy         (busy),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    always #(PERIOD / 2) clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    // UART stand-in: tx_done arrives done_delay cycles after each tx_start it sees.
    initial begin : uart_model
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clock);
            #2;
            uart_done = 1'b0;
            if (reset) begin
                cnt = 0;
            end else if (tx_start) begin
                cnt = respond ? done_delay : 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) uart_done = 1'b1;
            end
            uart_shift = (cnt > 0);
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clock);
            if (tx_start) begin
                checkOutput("start_not_back_to_back", 32'(prev_start), 0);
                start_cyc.push_back(cyc);
                start_byte.push_back(tx_data);
            end
            prev_start = tx_start;
            if (overrun) ovr_cyc.push_back(cyc);
            if (timeout) tmo_cyc.push_back(cyc);
        end
    end

    initial begin : watchdog
        #(PERIOD * 50000);
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [7:0] code, input logic [7:0] data, output int send_edge);
        response_code = code;
        response_data = data;
        send          = 1'b1;
        send_edge     = cyc + 1;
        step(1);
        send          = 1'b0;
        response_code = 8'($urandom);
        response_data = 8'($urandom);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_tx_start"}, 32'(tx_start), 0);
        checkOutput({tag, "_tx_data"}, 32'(tx_data), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_overrun"}, 32'(overrun), 0);
        checkOutput({tag, "_timeout"}, 32'(timeout), 0);
    endtask

    // One complete frame. hold: cycles tx_busy stays high after send; intrude: 0 none,
    // >0 rejected send that many cycles into WAIT_CODE, <0 rejected send with final tx_done.
    task automatic runFrame(input logic [7:0] code, input logic [7:0] data, input int d,
                            input int hold, input int intrude, input bit early);
        int base, ovr_base, se, e1, e2, fin, ie;
        base       = start_cyc.size();
        ovr_base   = ovr_cyc.size();
        done_delay = d;
        busy_force = (hold > 0);
        applyStimulus(code, data, se);
        model_bytes.push_back(code);
        model_bytes.push_back(data);
        e1  = se + 1 + hold;
        e2  = e1 + d + 2;
        fin = e2 + d + 1;
        ie  = (intrude < 0) ? fin : ((intrude > 0) ? e1 + intrude : 0);
        checkOutput("busy_after_send", 32'(busy), 1);
        while (cyc < fin) begin
            if (cyc == fin - 1) checkOutput("busy_before_last_done", 32'(busy), 1);
            if (cyc == se + hold) busy_force = 1'b0;
            stray_done = (hold > 2 && cyc == se + hold / 2) || (early && cyc == e1);
            send = (ie != 0 && cyc == ie - 1);
            if (send) begin
                response_code = 8'hFF;
                response_data = 8'($urandom);
            end
            step(1);
        end
        send       = 1'b0;
        stray_done = 1'b0;
        checkOutput("busy_after_frame", 32'(busy), 0);
        checkOutput("tx_data_held", 32'(tx_data), 32'(data));
        step(3);
        checkOutput("start_count", 32'(start_cyc.size() - base), 2);
        if (start_cyc.size() >= base + 2) begin
            checkOutput("code_start_edge", 32'(start_cyc[base]), 32'(e1));
            checkOutput("code_byte", 32'(start_byte[base]), 32'(code));
            checkOutput("data_start_edge", 32'(start_cyc[base + 1]), 32'(e2));
            checkOutput("data_byte", 32'(start_byte[base + 1]), 32'(data));
        end
        checkOutput("overrun_count", 32'(ovr_cyc.size() - ovr_base), (ie != 0) ? 1 : 0);
        if (ie != 0 && ovr_cyc.size() > ovr_base)
            checkOutput("overrun_edge", 32'(ovr_cyc[ovr_base]), 32'(ie));
    endtask

    initial begin : stimulus
        int base, tbase, se, e1, e2, t;
        logic [7:0] code, data;

        $display("[TB] reset state");
        reset         = 1'b1;
        send          = 1'b1;
        response_code = 8'hAA;
        response_data = 8'h55;
        step(1);
        checkResetOutputs("reset");
        step(1);
        send = 1'b0;
        step(1);
        reset = 1'b0;

        $display("[TB] nominal frame on first edge after reset");
        runFrame(8'h08, 8'h1A, 10, 0, 0, 1'b0);

        $display("[TB] stray tx_done while idle");
        base       = start_cyc.size();
        stray_done = 1'b1;
        step(1);
        stray_done = 1'b0;
        step(4);
        checkOutput("idle_stray_no_start", 32'(start_cyc.size() - base), 0);
        checkOutput("idle_stray_busy", 32'(busy), 0);

        $display("[TB] transmitter busy for 20 cycles");
        runFrame(8'($urandom), 8'($urandom), 6, 20, 0, 1'b0);

        $display("[TB] tx_done coincident with tx_start");
        runFrame(8'($urandom), 8'($urandom), 5, 0, 0, 1'b1);

        $display("[TB] send during WAIT_CODE");
        runFrame(8'($urandom), 8'($urandom), 8, 0, 3, 1'b0);

        $display("[TB] send with final tx_done");
        runFrame(8'($urandom), 8'($urandom), 4, 0, -1, 1'b0);

        $display("[TB] longest and shortest tx_done latency");
        runFrame(8'($urandom), 8'($urandom), TMO - 1, 0, 0, 1'b0);
        runFrame(8'($urandom), 8'($urandom), 1, 0, 0, 1'b0);

        $display("[TB] random frames");
        for (int i = 0; i < 4; i++) begin
            runFrame(8'($urandom), 8'($urandom), int'($urandom_range(1, TMO - 1)),
                     int'($urandom_range(0, 4)), 0, 1'($urandom_range(0, 1)));
        end

        $display("[TB] tx_done never arrives");
        base    = start_cyc.size();
        tbase   = tmo_cyc.size();
        respond = 1'b0;
        code    = 8'($urandom);
        applyStimulus(code, 8'($urandom), se);
        model_bytes.push_back(code);
        e1 = se + 1;
        t  = e1 + TMO;
        while (cyc < t - 1) step(1);
        checkOutput("timeout_busy_before", 32'(busy), 1);
        checkOutput("timeout_not_early", 32'(timeout), 0);
        step(1);
        checkOutput("timeout_pulse", 32'(timeout), 1);
        checkOutput("timeout_busy_after", 32'(busy), 0);
        step(1);
        checkOutput("timeout_one_cycle", 32'(timeout), 0);
        step(10);
        checkOutput("timeout_start_count", 32'(start_cyc.size() - base), 1);
        if (start_cyc.size() > base) begin
            checkOutput("timeout_code_edge", 32'(start_cyc[base]), 32'(e1));
            checkOutput("timeout_code_byte", 32'(start_byte[base]), 32'(code));
        end
        checkOutput("timeout_count", 32'(tmo_cyc.size() - tbase), 1);
        if (tmo_cyc.size() > tbase)
            checkOutput("timeout_edge", 32'(tmo_cyc[tbase]), 32'(t));
        respond = 1'b1;

        $display("[TB] reset during WAIT_DATA");
        base       = start_cyc.size();
        code       = 8'($urandom);
        data       = 8'($urandom);
        done_delay = 10;
        applyStimulus(code, data, se);
        e1 = se + 1;
        e2 = e1 + done_delay + 2;
        while (cyc < e2 + 3) step(1);
        #2;
        reset = 1'b1;
        send  = 1'b1;
        #1;
        checkResetOutputs("midframe_reset");
        step(1);
        send = 1'b0;
        step(1);
        reset = 1'b0;
        model_bytes.push_back(code);
        model_bytes.push_back(data);
        step(4);
        checkOutput("reset_abort_start_count", 32'(start_cyc.size() - base), 2);
        checkOutput("reset_abort_busy", 32'(busy), 0);
        runFrame(8'($urandom), 8'($urandom), 7, 0, 0, 1'b0);

        checkOutput("byte_log_length", 32'(start_byte.size()), 32'(model_bytes.size()));
        for (int i = 0; i < start_byte.size() && i < model_bytes.size(); i++)
            checkOutput("byte_log_entry", 32'(start_byte[i]), 32'(model_bytes[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
